// File: rtl/status_read_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : status_read_ctrl_pkg
// Description : Shared FSM encodings and address-map constants for the
//               status register read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package status_read_ctrl_pkg;

    localparam int c_n_regs     = 19;
    localparam int c_addr_w     = 6;
    localparam int c_snap_base  = 32;
    localparam int c_ts_lsb_idx = 11;
    localparam int c_ts_msb_idx = 12;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_dec  = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;
    localparam logic [1:0] c_st_hold = 2'd3;

endpackage
`default_nettype wire

// File: rtl/status_snapshot_ram.sv
`default_nettype none
// ============================================================================
// Module      : status_snapshot_ram
// Description : N_REGS x 32 capture array, loaded from all live words in one
//               cycle, with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module status_snapshot_ram #(
    parameter int N_REGS = 19,
    parameter int IDX_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REGS*32-1:0]  i_status_flat,
    input  logic                  i_cap_en,
    input  logic                  i_rd_en,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [31:0]           o_rd_data
);

    logic [31:0] r_mem [N_REGS];
    logic [31:0] r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) r_mem[i] <= '0;
        end else if (i_cap_en) begin
            for (int i = 0; i < N_REGS; i++) r_mem[i] <= i_status_flat[32*i +: 32];
        end
    end

    // Read and capture share an edge, so a coincident read sees the old contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          r_rd_data <= '0;
        else if (i_rd_en) r_rd_data <= r_mem[i_rd_idx];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/status_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : status_read_ctrl
// Description : IPbus read sequencer for the status register file with
//               coherent timestamp pair reads and a frozen snapshot copy.
// Revision    : 1.0 - initial release
// ============================================================================
module status_read_ctrl
    import status_read_ctrl_pkg::*;
#(
    parameter int N_REGS     = c_n_regs,
    parameter int ADDR_W     = c_addr_w,
    parameter int SNAP_BASE  = c_snap_base,
    parameter int TS_LSB_IDX = c_ts_lsb_idx,
    parameter int TS_MSB_IDX = c_ts_msb_idx
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_REGS*32-1:0]  status_flat,
    input  logic                  snap_req,
    input  logic                  ipb_strobe,
    input  logic                  ipb_write,
    input  logic [ADDR_W-1:0]     ipb_addr,
    output logic [31:0]           ipb_rdata,
    output logic                  ipb_ack,
    output logic                  ipb_err,
    output logic                  snap_valid,
    output logic [15:0]           err_count
);

    localparam int IDX_W = $clog2(N_REGS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_capture;
    logic              w_dec;
    logic              w_resp;

    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic              r_is_err;
    logic              r_snap_sel;
    logic [31:0]       r_rdata;
    logic [31:0]       r_ts_shadow;
    logic              r_ts_shadow_vld;
    logic              r_snap_valid;
    logic [15:0]       r_err_count;

    logic [31:0]       w_live [N_REGS];
    logic [31:0]       w_addr32;
    logic [IDX_W-1:0]  w_live_idx;
    logic [IDX_W-1:0]  w_snap_idx;
    logic              w_in_live;
    logic              w_in_snap;
    logic              w_ts_lsb_rd;
    logic              w_ts_msb_rd;
    logic [31:0]       w_live_rd;
    logic [31:0]       w_snap_q;

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_live
            assign w_live[gi] = status_flat[32*gi +: 32];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (ipb_strobe)  w_state_nxt = c_st_dec;
            c_st_dec:                   w_state_nxt = c_st_resp;
            c_st_resp:                  w_state_nxt = c_st_hold;
            c_st_hold: if (!ipb_strobe) w_state_nxt = c_st_idle;
            default:                    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_capture = (r_state == c_st_idle) && ipb_strobe;
        w_dec     = (r_state == c_st_dec);
        w_resp    = (r_state == c_st_resp);
        ipb_ack   = w_resp && !r_is_err;
        ipb_err   = w_resp && r_is_err;
    end

    assign w_addr32    = {{(32-ADDR_W){1'b0}}, r_addr};
    assign w_live_idx  = IDX_W'(r_addr);
    assign w_snap_idx  = IDX_W'(r_addr - ADDR_W'(SNAP_BASE));
    assign w_in_live   = !r_write && (w_addr32 < N_REGS);
    assign w_in_snap   = !r_write && (w_addr32 >= SNAP_BASE) && (w_addr32 < SNAP_BASE + N_REGS);
    assign w_ts_lsb_rd = w_dec && w_in_live && (w_live_idx == IDX_W'(TS_LSB_IDX));
    assign w_ts_msb_rd = w_dec && w_in_live && (w_live_idx == IDX_W'(TS_MSB_IDX));

    // An MSB read following an LSB read returns the MSB as it was at LSB time.
    assign w_live_rd = (w_ts_msb_rd && r_ts_shadow_vld) ? r_ts_shadow : w_live[w_live_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr          <= '0;
            r_write         <= 1'b0;
            r_is_err        <= 1'b0;
            r_snap_sel      <= 1'b0;
            r_rdata         <= '0;
            r_ts_shadow     <= '0;
            r_ts_shadow_vld <= 1'b0;
            r_snap_valid    <= 1'b0;
            r_err_count     <= '0;
        end else begin
            if (w_capture) begin
                r_addr  <= ipb_addr;
                r_write <= ipb_write;
            end
            if (w_dec) begin
                r_is_err   <= !(w_in_live || w_in_snap);
                r_snap_sel <= w_in_snap && r_snap_valid;
                r_rdata    <= w_in_live ? w_live_rd : 32'd0;
            end
            if (w_ts_lsb_rd) begin
                r_ts_shadow     <= w_live[TS_MSB_IDX];
                r_ts_shadow_vld <= 1'b1;
            end else if (w_ts_msb_rd) begin
                r_ts_shadow_vld <= 1'b0;
            end
            if (snap_req) r_snap_valid <= 1'b1;
            if (ipb_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
        end
    end

    status_snapshot_ram #(
        .N_REGS (N_REGS),
        .IDX_W  (IDX_W)
    ) u_snapshot (
        .clk           (clk),
        .rst           (reset),
        .i_status_flat (status_flat),
        .i_cap_en      (snap_req),
        .i_rd_en       (w_dec && w_in_snap),
        .i_rd_idx      (w_snap_idx),
        .o_rd_data     (w_snap_q)
    );

    assign ipb_rdata  = ipb_ack ? (r_snap_sel ? w_snap_q : r_rdata) : 32'd0;
    assign snap_valid = r_snap_valid;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_status_read_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_status_read_ctrl
// Description : Self-checking bench for status_read_ctrl with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_status_read_ctrl;

    localparam int NR = 19;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*32-1:0]  status_flat;
    logic              snap_req;
    logic              ipb_strobe;
    logic              ipb_write;
    logic [5:0]        ipb_addr;
    logic [31:0]       ipb_rdata;
    logic              ipb_ack;
    logic              ipb_err;
    logic              snap_valid;
    logic [15:0]       err_count;

    logic [31:0] live   [NR];
    logic [31:0] m_snap [NR];
    logic        m_snap_vld;
    logic [31:0] m_shadow;
    logic        m_shadow_vld;
    logic [15:0] m_errs;
    exp_t        exp_q [$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    status_read_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .status_flat (status_flat),
        .snap_req    (snap_req),
        .ipb_strobe  (ipb_strobe),
        .ipb_write   (ipb_write),
        .ipb_addr    (ipb_addr),
        .ipb_rdata   (ipb_rdata),
        .ipb_ack     (ipb_ack),
        .ipb_err     (ipb_err),
        .snap_valid  (snap_valid),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        status_flat = '0;
        for (int i = 0; i < NR; i++) status_flat[32*i +: 32] = live[i];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_snap[i] = '0;
        m_snap_vld   = 1'b0;
        m_shadow     = '0;
        m_shadow_vld = 1'b0;
        m_errs       = '0;
    endtask

    task automatic model_capture();
        for (int i = 0; i < NR; i++) m_snap[i] = live[i];
        m_snap_vld = 1'b1;
    endtask

    // Address map: live 0..18, snapshot 32..50, writes and everything else fail.
    task automatic model_predict(input bit w, input int a, output bit e, output logic [31:0] d);
        e = 1'b0;
        d = '0;
        if (w) begin
            e = 1'b1;
        end else if (a < NR) begin
            d = live[a];
            if (a == 11) begin
                m_shadow     = live[12];
                m_shadow_vld = 1'b1;
            end else if (a == 12) begin
                if (m_shadow_vld) d = m_shadow;
                m_shadow_vld = 1'b0;
            end
        end else if (a >= 32 && a < 32 + NR) begin
            d = m_snap_vld ? m_snap[a-32] : 32'd0;
        end else begin
            e = 1'b1;
        end
        if (e && m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
    endtask

    always @(negedge clk) begin
        bit          ea;
        bit          ee;
        logic [31:0] ed;
        exp_t        t;
        ea = 1'b0;
        ee = 1'b0;
        ed = '0;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) t = exp_q.pop_front();
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            t  = exp_q.pop_front();
            ea = !t.err;
            ee = t.err;
            ed = t.data;
        end
        check("cyc_ack", {31'd0, ipb_ack}, {31'd0, ea});
        check("cyc_err", {31'd0, ipb_err}, {31'd0, ee});
        if (ea) check("cyc_rdata", ipb_rdata, ed);
    end

    task automatic do_txn(input bit w, input int a, input int hold, input bit snap_in_dec,
                          output logic [31:0] d, output bit e);
        bit          seen;
        bit          pe;
        logic [31:0] pd;
        exp_t        t;
        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_write  = w;
        ipb_addr   = 6'(a);
        model_predict(w, a, pe, pd);
        t.cyc  = cyc + 2;
        t.err  = pe;
        t.data = pd;
        exp_q.push_back(t);
        if (snap_in_dec) model_capture();
        seen = 1'b0;
        d    = '0;
        e    = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            snap_req = snap_in_dec && (i == 0);
            if (ipb_ack || ipb_err) begin
                seen = 1'b1;
                d    = ipb_rdata;
                e    = ipb_err;
            end
        end
        snap_req = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL txn_timeout: addr %0d got no response, expected ack or err", a);
        end
        repeat (hold) @(negedge clk);
        ipb_strobe = 1'b0;
        ipb_write  = 1'b0;
        @(negedge clk);
        check("err_count", {16'd0, err_count}, {16'd0, m_errs});
        check("snap_valid", {31'd0, snap_valid}, {31'd0, m_snap_vld});
    endtask

    task automatic pulse_snap();
        @(negedge clk);
        snap_req = 1'b1;
        model_capture();
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit          e;
        reset      = 1'b1;
        snap_req   = 1'b0;
        ipb_strobe = 1'b0;
        ipb_write  = 1'b0;
        ipb_addr   = '0;
        for (int i = 0; i < NR; i++) live[i] = 32'hA000_0000 + 32'(i * 32'h0101);
        live[0] = 32'h4001_0203;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rdata", ipb_rdata, 32'd0);
        check("rst_ack", {31'd0, ipb_ack}, 32'd0);
        check("rst_err", {31'd0, ipb_err}, 32'd0);
        check("rst_snap_valid", {31'd0, snap_valid}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_txn(0, 0, 0, 0, d, e);
        check("rd0_data", d, 32'h4001_0203);
        check("rd0_err", {31'd0, e}, 32'd0);
        do_txn(0, 5, 1, 0, d, e);
        do_txn(0, 18, 0, 0, d, e);
        check("rd18_data", d, 32'hA000_1212);

        do_txn(1, 3, 0, 0, d, e);
        check("wr3_err", {31'd0, e}, 32'd1);
        check("wr3_cnt", {16'd0, err_count}, 32'd1);
        do_txn(0, 19, 0, 0, d, e);
        check("rd19_err", {31'd0, e}, 32'd1);
        check("rd19_cnt", {16'd0, err_count}, 32'd2);
        do_txn(0, 31, 0, 0, d, e);
        do_txn(0, 51, 0, 0, d, e);
        do_txn(0, 63, 0, 0, d, e);
        do_txn(1, 40, 0, 0, d, e);

        do_txn(0, 32, 0, 0, d, e);
        check("snap_before_valid", d, 32'd0);

        live[12] = 32'd5;
        do_txn(0, 11, 0, 0, d, e);
        live[12] = 32'd9;
        do_txn(0, 12, 0, 0, d, e);
        check("ts_msb_shadow", d, 32'd5);
        do_txn(0, 12, 0, 0, d, e);
        check("ts_msb_live", d, 32'd9);

        live[10] = 32'd7;
        pulse_snap();
        live[10] = 32'd8;
        do_txn(0, 42, 0, 0, d, e);
        check("snap_rd10", d, 32'd7);
        do_txn(0, 10, 0, 0, d, e);
        check("live_rd10", d, 32'd8);
        do_txn(0, 50, 0, 0, d, e);

        live[10] = 32'h55;
        do_txn(0, 42, 0, 1, d, e);
        check("snap_same_cycle_old", d, 32'd7);
        do_txn(0, 42, 0, 0, d, e);
        check("snap_same_cycle_new", d, 32'h55);

        do_txn(0, 1, 9, 0, d, e);

        @(negedge clk);
        ipb_strobe = 1'b1;
        ipb_addr   = 6'd0;
        @(negedge clk);
        reset      = 1'b1;
        ipb_strobe = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("mid_rst_err_count", {16'd0, err_count}, 32'd0);
        check("mid_rst_snap_valid", {31'd0, snap_valid}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        do_txn(0, 42, 0, 0, d, e);
        check("post_rst_snap", d, 32'd0);
        do_txn(0, 12, 0, 0, d, e);
        check("post_rst_ts", d, 32'd9);

        @(negedge clk);
        force dut.r_err_count = 16'hFFFE;
        @(negedge clk);
        release dut.r_err_count;
        m_errs = 16'hFFFE;
        do_txn(1, 3, 0, 0, d, e);
        do_txn(0, 19, 0, 0, d, e);
        do_txn(0, 60, 0, 0, d, e);
        check("sat_final", {16'd0, err_count}, 32'h0000_FFFF);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
